// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the parametrised NTT control FSM.
//   mode_e  : operation encodings latched at start acceptance
//   state_e : controller states IDLE/RUN/DRAIN/DONE
//   k_w/p_w : width helpers for block/in-block counters and stage index
package ntt_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_NTT  = 2'd0,
    MODE_PWM  = 2'd1,
    MODE_INTT = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of k and i: one issue cycle per BFU group, C = 2^(LOGN-LOG_NBFU).
  function automatic int k_w(input int logn, input int log_nbfu);
    return logn - log_nbfu;
  endfunction

  // Width of p: stages span 0..LOGN inclusive.
  function automatic int p_w(input int logn);
    return $clog2(logn + 1);
  endfunction

endpackage

// File: rtl/ntt_ctrl_fsm_param_if.sv
// Handshake/strobe bundle between the top-level sequencer (master) and the
// NTT controller (slave).
//   start/mode/stall : sequencer -> controller
//   busy/done/sel    : operation status
//   p/k/i            : stage, block and in-block counters
//   ren/en_tf_rom    : read + twiddle ROM strobes, en/wen : delayed BFU/write
interface ntt_ctrl_fsm_param_if #(
  parameter int LOGN     = 9,
  parameter int LOG_NBFU = 3
);
  import ntt_ctrl_pkg::*;

  logic                                start;
  logic [1:0]                          mode;
  logic                                stall;
  logic                                busy;
  logic                                done;
  logic                                sel;
  logic [p_w(LOGN)-1:0]                p;
  logic [k_w(LOGN, LOG_NBFU)-1:0]      k;
  logic [k_w(LOGN, LOG_NBFU)-1:0]      i;
  logic                                ren;
  logic                                en_tf_rom;
  logic                                en;
  logic                                wen;

  modport master (
    output start, mode, stall,
    input  busy, done, sel, p, k, i, ren, en_tf_rom, en, wen
  );

  modport slave (
    input  start, mode, stall,
    output busy, done, sel, p, k, i, ren, en_tf_rom, en, wen
  );

endinterface

// File: rtl/ctrl_delay_line.sv
// Synchronous-reset shift register delaying a WIDTH-bit value by DEPTH
// cycles. DEPTH=0 degenerates to a wire.
//   clk, rst : clock, synchronous active-high reset (clears all stages)
//   din/dout : input / DEPTH-cycle delayed output
module ctrl_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] vld_pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= din;
        for (int s = 1; s < DEPTH; s++) vld_pipe[s] <= vld_pipe[s-1];
      end
    end

    assign dout = vld_pipe[DEPTH-1];
  end

endmodule

// File: rtl/ntt_ctrl_fsm_param.sv
// Parametrised control/address FSM for the radix-2 NTT core.
// Walks stage p, block k and in-block index i for NTT (p LOGN->0),
// INTT (p 0->LOGN) and PWM (single pass at p=0), issuing one read per cycle
// in RUN, then drains the BFU pipeline for PIPE_DEPTH cycles before a
// one-cycle DONE.
// Ports:
//   clk, rst : clock, synchronous active-high reset (aborts, no done)
//   bus      : ntt_ctrl_fsm_param_if.slave (start/mode/stall in,
//              busy/done/sel/p/k/i/ren/en_tf_rom/en/wen out)
// Build option: define NTT_CTRL_STALL_EN to let stall freeze issue in RUN;
// otherwise stall is ignored.
module ntt_ctrl_fsm_param
  import ntt_ctrl_pkg::*;
#(
  parameter int LOGN       = 9,
  parameter int LOG_NBFU   = 3,
  parameter int PIPE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ntt_ctrl_fsm_param_if.slave   bus
);

  localparam int K_W = k_w(LOGN, LOG_NBFU);
  localparam int P_W = p_w(LOGN);
  localparam int D_W = $clog2(PIPE_DEPTH + 1);

  localparam logic [P_W-1:0] P_MAX = P_W'(LOGN);
  localparam logic [P_W-1:0] P_BFU = P_W'(LOG_NBFU);
  localparam logic [K_W-1:0] ONES  = '1;
  localparam logic [D_W-1:0] D_END = D_W'(PIPE_DEPTH - 1);

  state_e         state_q, state_d;
  mode_e          mode_q, mode_d;
  logic [P_W-1:0] p_q, p_d;
  logic [K_W-1:0] k_q, k_d, i_q, i_d;
  logic [D_W-1:0] dcnt_q, dcnt_d;

  logic           issue;
  logic           wide;
  logic           last_stage;
  logic           last_issue;
  logic [K_W-1:0] i_max, k_max;

`ifdef NTT_CTRL_STALL_EN
  assign issue = (state_q == RUN) && !bus.stall;
`else
  logic unused_stall;
  assign unused_stall = bus.stall;
  assign issue        = (state_q == RUN);
`endif

  // Wide stage: J=2^p spans at least one full BFU group, so i walks
  // J/2^LOG_NBFU positions and k walks 2^LOGN/J blocks. Narrow stages keep
  // i at 0 and let k cover all C issue cycles.
  assign wide  = (p_q >= P_BFU);
  assign i_max = wide ? ~(ONES << (p_q - P_BFU)) : '0;
  assign k_max = wide ? ~(ONES << (P_MAX - p_q)) : ONES;

  always_comb begin
    last_stage = 1'b1;
    case (mode_q)
      MODE_NTT:  last_stage = (p_q == '0);
      MODE_INTT: last_stage = (p_q == P_MAX);
      default:   last_stage = 1'b1;
    endcase
  end

  assign last_issue = issue && (i_q == i_max) && (k_q == k_max) && last_stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_NTT;
      p_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      k_q     <= k_d;
      i_q     <= i_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    p_d     = p_q;
    k_d     = k_q;
    i_d     = i_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.mode != MODE_RSVD)) begin
          state_d = RUN;
          mode_d  = mode_e'(bus.mode);
          p_d     = (bus.mode == MODE_NTT) ? P_MAX : '0;
          k_d     = '0;
          i_d     = '0;
        end
      end
      RUN: begin
        if (last_issue) begin
          state_d = DRAIN;
          p_d     = '0;
          k_d     = '0;
          i_d     = '0;
          dcnt_d  = '0;
        end else if (issue) begin
          if (i_q != i_max) begin
            i_d = i_q + 1'b1;
          end else begin
            i_d = '0;
            if (k_q != k_max) begin
              k_d = k_q + 1'b1;
            end else begin
              // Stage boundary; PWM never gets here (single stage = last).
              k_d = '0;
              p_d = (mode_q == MODE_NTT) ? p_q - 1'b1 : p_q + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == D_END) state_d = DONE;
        else                 dcnt_d  = dcnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.sel       = (state_q != IDLE) && (mode_q == MODE_INTT);
  assign bus.p         = p_q;
  assign bus.k         = k_q;
  assign bus.i         = i_q;
  assign bus.ren       = issue;
  assign bus.en_tf_rom = issue;

  ctrl_delay_line #(.DEPTH(PIPE_DEPTH - 1), .WIDTH(1)) u_en_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (issue),
    .dout (bus.en)
  );

  ctrl_delay_line #(.DEPTH(PIPE_DEPTH), .WIDTH(1)) u_wen_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (issue),
    .dout (bus.wen)
  );

endmodule

// File: tb/tb_ntt_ctrl_fsm_param.sv
// Scoreboard bench for ntt_ctrl_fsm_param with default parameters.
// Stimulus pushes the expected issue sequence and done cycle; a negedge
// monitor pops and compares whenever ren or done is presented.
module tb_ntt_ctrl_fsm_param;
  import ntt_ctrl_pkg::*;

  localparam int LOGN       = 9;
  localparam int LOG_NBFU   = 3;
  localparam int PIPE_DEPTH = 8;
  localparam int C          = 1 << (LOGN - LOG_NBFU);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_ctrl_fsm_param_if #(.LOGN(LOGN), .LOG_NBFU(LOG_NBFU)) bus();

  ntt_ctrl_fsm_param #(
    .LOGN(LOGN), .LOG_NBFU(LOG_NBFU), .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0     = 0;

  int exp_iss[$];
  int exp_done[$];
  int wen_cnt, en_cnt, tf_cnt, busy_cnt, sel_cnt, done_cnt, last_wen, last_iss;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  function automatic int code(input int p, input int k, input int i);
    return (p << 16) | (k << 8) | i;
  endfunction

  task automatic push_stage(input int p);
    if (p >= LOG_NBFU) begin
      for (int k = 0; k < (1 << (LOGN - p)); k++)
        for (int i = 0; i < (1 << (p - LOG_NBFU)); i++)
          exp_iss.push_back(code(p, k, i));
    end else begin
      for (int k = 0; k < C; k++) exp_iss.push_back(code(p, k, 0));
    end
  endtask

  task automatic push_op(input int m);
    if (m == 0)      for (int p = LOGN; p >= 0; p--) push_stage(p);
    else if (m == 2) for (int p = 0; p <= LOGN; p++) push_stage(p);
    else             for (int k = 0; k < C; k++) exp_iss.push_back(code(0, k, 0));
  endtask

  task automatic clr_counts();
    wen_cnt = 0; en_cnt = 0; tf_cnt = 0; busy_cnt = 0; sel_cnt = 0;
    done_cnt = 0; last_wen = -1; last_iss = -1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares on every presented read issue and done pulse.
  initial begin
    int a;
    forever begin
      @(negedge clk);
      if (bus.ren) begin
        a = code(int'(bus.p), int'(bus.k), int'(bus.i));
        last_iss = a;
        if (exp_iss.size() == 0) chk("unexpected ren", a, -1);
        else                     chk("issue p/k/i", a, exp_iss.pop_front());
      end
      if (bus.en_tf_rom) tf_cnt++;
      if (bus.wen) begin wen_cnt++; last_wen = cyc - t0; end
      if (bus.en)   en_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.sel)  sel_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (exp_done.size() == 0) chk("unexpected done", cyc - t0, -1);
        else                      chk("done cycle", cyc - t0, exp_done.pop_front());
      end
    end
  end

  // One operation from IDLE; optional stall window and stray start injection.
  task automatic run_op(input logic [1:0] m, input int len, input int stall_at,
                        input int n_stall, input int inj_at, input logic [1:0] inj_mode);
    int total;
    total = len + PIPE_DEPTH + 1 + n_stall;
    @(posedge clk); #1;
    clr_counts();
    t0 = cyc;
    exp_iss.delete();
    exp_done.delete();
    push_op(int'(m));
    exp_done.push_back(total);
    bus.start = 1'b1;
    bus.mode  = m;
    for (int c = 1; c < total + 20; c++) begin
      @(posedge clk); #1;
      bus.start = (c == inj_at);
      if (c == inj_at) bus.mode = inj_mode;
      bus.stall = (c >= stall_at) && (c < stall_at + n_stall);
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    chk("done count", done_cnt, 1);
    chk("wen count", wen_cnt, len);
    chk("en count", en_cnt, len);
    chk("tf rom count", tf_cnt, len);
    chk("last wen cycle", last_wen, len + PIPE_DEPTH + n_stall);
    chk("busy cycles", busy_cnt, total);
    chk("sel cycles", sel_cnt, (m == 2'd2) ? total : 0);
    chk("issues left", exp_iss.size(), 0);
    chk("idle busy", int'(bus.busy), 0);
    exp_done.delete();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.stall = 1'b0;
    clr_counts();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset outputs", int'({bus.busy, bus.done, bus.sel, bus.ren, bus.en_tf_rom,
                               bus.en, bus.wen, bus.p, bus.k, bus.i}), 0);

    // NTT, with a start in DONE (cycle 649) that must be ignored.
    run_op(2'd0, 640, -1, 0, 649, 2'd1);
    chk("ntt last issue", last_iss, code(0, 63, 0));

    // INTT, with a stray PWM start mid-RUN that must be ignored.
    run_op(2'd2, 640, -1, 0, 100, 2'd1);
    chk("intt last issue", last_iss, code(9, 0, 63));

    // PWM: 64 issues, done at 73.
    run_op(2'd1, 64, -1, 0, -1, 2'd0);
    chk("pwm last issue", last_iss, code(0, 63, 0));

    // Reserved mode in IDLE is ignored.
    @(posedge clk); #1;
    clr_counts();
    t0 = cyc;
    bus.start = 1'b1;
    bus.mode  = 2'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mode3 busy", busy_cnt, 0);
    chk("mode3 ren", tf_cnt, 0);
    chk("mode3 done", done_cnt, 0);

    // Reset at cycle 300 of an NTT aborts with no done and no further wen.
    @(posedge clk); #1;
    clr_counts();
    t0 = cyc;
    exp_iss.delete();
    exp_done.delete();
    push_op(0);
    bus.start = 1'b1;
    bus.mode  = 2'd0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_iss.delete();
    wen_cnt  = 0;
    done_cnt = 0;
    @(negedge clk);
    chk("abort outputs", int'({bus.busy, bus.done, bus.sel, bus.ren, bus.en_tf_rom,
                               bus.en, bus.wen, bus.p, bus.k, bus.i}), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort wen", wen_cnt, 0);
    chk("abort done", done_cnt, 0);
    chk("abort ren", exp_iss.size(), 0);

    // Normal operation after the abort.
    run_op(2'd1, 64, -1, 0, -1, 2'd0);

`ifdef NTT_CTRL_STALL_EN
    // 5-cycle stall mid-stage delays done by exactly 5 cycles.
    run_op(2'd0, 640, 200, 5, -1, 2'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
